// File: rtl/intr_ctrl_pkg.sv
// Shared encodings for the interrupt sequencer: PC mux selects, FSM states
// and the default handler entry point.
package intr_pkg;

  localparam logic [1:0] PC_SEL_SEQ     = 2'b00;
  localparam logic [1:0] PC_SEL_HANDLER = 2'b01;
  localparam logic [1:0] PC_SEL_EPC     = 2'b10;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;

endpackage

// File: rtl/intr_ctrl_if.sv
// Pipeline/CP0 side signals of the interrupt sequencer. The master modport is
// the controller; the slave modport is the pipeline and CP0 that it steers.
interface intr_ctrl_if #(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_mask_i;
  logic               ie_i;
  logic               ex_valid_i;
  logic [31:0]        ex_pc_i;
  logic               hz_stall_i;
  logic               eret_i;
  logic               flush_if_id_o;
  logic               flush_id_ex_o;
  logic               flush_ex_mem_o;
  logic [1:0]         pc_sel_o;
  logic [31:0]        handler_pc_o;
  logic               epc_we_o;
  logic [31:0]        epc_o;
  logic               cause_we_o;
  logic [NUM_IRQ-1:0] cause_o;
  logic               ie_clr_o;
  logic               ie_set_o;
  logic               intr_active_o;

  modport master (
    input  irq_i, irq_mask_i, ie_i, ex_valid_i, ex_pc_i, hz_stall_i, eret_i,
    output flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, pc_sel_o, handler_pc_o,
           epc_we_o, epc_o, cause_we_o, cause_o, ie_clr_o, ie_set_o, intr_active_o
  );

  modport slave (
    output irq_i, irq_mask_i, ie_i, ex_valid_i, ex_pc_i, hz_stall_i, eret_i,
    input  flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, pc_sel_o, handler_pc_o,
           epc_we_o, epc_o, cause_we_o, cause_o, ie_clr_o, ie_set_o, intr_active_o
  );
endinterface

// File: rtl/intr_ctrl_irq_prio_enc.sv
// Fixed-priority encoder: one-hot of the lowest-index pending line plus an
// any-pending flag. Purely combinational.
module irq_prio_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] pend_i,
  output logic [NUM_IRQ-1:0] sel_o,
  output logic               any_o
);

  logic found;

  always_comb begin
    sel_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pend_i[i] && !found) begin
        sel_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any_o = |pend_i;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt sequencer for the 5-stage pipeline: synchronises IRQs, waits for a
// real unstalled EX instruction, kills it, saves its PC as EPC and tracks the handler.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int          NUM_IRQ      = 4,
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  intr_ctrl_if.master bus
);

  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] sel;
  logic               any_pend;
  state_e             state_q, state_d;

  always_comb begin
    sync1_d = bus.irq_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
    end
  end

  assign pend = sync2_q & bus.irq_mask_i;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .pend_i (pend),
    .sel_o  (sel),
    .any_o  (any_pend)
  );

  assign bus.handler_pc_o = HANDLER_ADDR;

  // The take cycle kills the EX instruction; MEM is left to commit.
  always_comb begin
    state_d            = state_q;
    bus.flush_if_id_o  = 1'b0;
    bus.flush_id_ex_o  = 1'b0;
    bus.flush_ex_mem_o = 1'b0;
    bus.pc_sel_o       = PC_SEL_SEQ;
    bus.epc_we_o       = 1'b0;
    bus.epc_o          = 32'h0;
    bus.cause_we_o     = 1'b0;
    bus.cause_o        = '0;
    bus.ie_clr_o       = 1'b0;
    bus.ie_set_o       = 1'b0;
    bus.intr_active_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.ie_i && any_pend) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!any_pend) begin
          state_d = ST_IDLE;
        end else if (bus.ex_valid_i && !bus.hz_stall_i) begin
          state_d            = ST_HANDLER;
          bus.flush_if_id_o  = 1'b1;
          bus.flush_id_ex_o  = 1'b1;
          bus.flush_ex_mem_o = 1'b1;
          bus.pc_sel_o       = PC_SEL_HANDLER;
          bus.epc_we_o       = 1'b1;
          bus.epc_o          = bus.ex_pc_i;
          bus.cause_we_o     = 1'b1;
          bus.cause_o        = sel;
          bus.ie_clr_o       = 1'b1;
        end
      end
      ST_HANDLER: begin
        bus.intr_active_o = 1'b1;
        if (bus.eret_i) begin
          state_d           = ST_IDLE;
          bus.pc_sel_o      = PC_SEL_EPC;
          bus.flush_if_id_o = 1'b1;
          bus.ie_set_o      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
